// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one memory port between the ICache line-fill path and the DCache
//   line-fill and write-back paths. It serves one transaction at a time. A
//   dirty write-back always wins arbitration. Read fills are round-robin
//   between the two caches.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ic_rd_req/ic_rd_addr     ICache line-fill request (held until ic_ret_last)
//   ic_ret_valid/ic_ret_last return beat strobes for the ICache
//   dc_rd_req/dc_rd_addr     DCache line-fill request (held until dc_ret_last)
//   dc_ret_valid/dc_ret_last return beat strobes for the DCache
//   ret_data                 shared return data, passthrough of mem_ret_data
//   dc_wr_req/dc_wr_addr     DCache write-back request (held until dc_wr_done)
//   dc_wr_line               dirty line, word 0 in the LSBs
//   dc_wr_done               one-cycle write-back completion pulse
//   mem_rd_*                 memory read command / handshake / return beats
//   mem_wr_*                 memory write beats / handshake / burst response
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ic_rd_req,
  input  logic [ADDR_W-1:0]            ic_rd_addr,
  output logic                         ic_ret_valid,
  output logic                         ic_ret_last,
  input  logic                         dc_rd_req,
  input  logic [ADDR_W-1:0]            dc_rd_addr,
  output logic                         dc_ret_valid,
  output logic                         dc_ret_last,
  output logic [DATA_W-1:0]            ret_data,
  input  logic                         dc_wr_req,
  input  logic [ADDR_W-1:0]            dc_wr_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] dc_wr_line,
  output logic                         dc_wr_done,
  output logic                         mem_rd_req,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic                         mem_rd_ack,
  input  logic                         mem_ret_valid,
  input  logic                         mem_ret_last,
  input  logic [DATA_W-1:0]            mem_ret_data,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_W-1:0]            mem_wr_data,
  output logic                         mem_wr_last,
  input  logic                         mem_wr_ack,
  input  logic                         mem_wr_resp
);

  localparam int unsigned CNT_W = $clog2(LINE_WORDS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  logic [2:0]                   state_q, state_d;
  logic                         owner_q, owner_d;
  logic                         rr_last_q, rr_last_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [LINE_WORDS*DATA_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [DATA_W-1:0] words [LINE_WORDS];
  logic              last_word;
  logic              rd_pick_dc;

  always_comb begin
    for (int unsigned i = 0; i < LINE_WORDS; i++) begin
      words[i] = line_q[i*DATA_W +: DATA_W];
    end
  end

  assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));

  // DC wins a read grant when it is the only reader, or on a tie when IC
  // was the previous read winner.
  assign rd_pick_dc = dc_rd_req && (!ic_rd_req || (rr_last_q == OWN_IC));

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    line_d    = line_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dc_wr_req) begin
          owner_d = OWN_DC;
          addr_d  = dc_wr_addr;
          line_d  = dc_wr_line;
          cnt_d   = '0;
          state_d = S_WR_DATA;
        end else if (ic_rd_req || dc_rd_req) begin
          owner_d = rd_pick_dc ? OWN_DC : OWN_IC;
          addr_d  = rd_pick_dc ? dc_rd_addr : ic_rd_addr;
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        // A beat arriving together with the command ack is ignored.
        if (mem_rd_ack) begin
          rr_last_d = owner_q;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        // The burst ends on the memory's last flag; beats are not counted.
        if (mem_ret_valid && mem_ret_last) begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        if (mem_wr_ack) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_word) begin
            state_d = S_WR_RESP;
          end
        end
      end
      S_WR_RESP: begin
        if (mem_wr_resp) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IC;
      rr_last_q <= OWN_DC;
      addr_q    <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
    end
  end

  // Command strobes decode registered state only; return strobes pass the
  // memory beat through with no added latency.
  always_comb begin
    mem_rd_req   = 1'b0;
    mem_rd_addr  = '0;
    mem_wr_req   = 1'b0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_wr_last  = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    dc_wr_done   = 1'b0;
    case (state_q)
      S_RD_ADDR: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = addr_q;
      end
      S_RD_DATA: begin
        if (owner_q == OWN_DC) begin
          dc_ret_valid = mem_ret_valid;
          dc_ret_last  = mem_ret_valid && mem_ret_last;
        end else begin
          ic_ret_valid = mem_ret_valid;
          ic_ret_last  = mem_ret_valid && mem_ret_last;
        end
      end
      S_WR_DATA: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = addr_q;
        mem_wr_data = words[cnt_q];
        mem_wr_last = last_word;
      end
      S_WR_RESP: begin
        dc_wr_done = mem_wr_resp;
      end
      default: ;
    endcase
  end

  assign ret_data = mem_ret_data;

endmodule
